term_writer: RTL

Hardware text-terminal engine that turns a byte stream (UART RX or CPU port) into character-cell writes for the 80x30 console RAM of the HDMI video block. It drives the video block's external framebuffer write port (`fb_a`/`fb_d`/`fb_we`, used when `FBEXT_ENABLE=1`). It tracks the cursor and interprets a small set of control codes. It clears the screen after reset and on form feed, and clears each newly entered line on wrap.

---
 rtl/quasi_term_pkg.sv | 27 ++
 rtl/term_writer.sv | 135 +++++++++++++
 2 files changed

// File: rtl/quasi_term_pkg.sv
// Shared constants, control codes and FSM state type for the text-terminal writer.
package quasi_term_pkg;

  localparam int DEF_COLS = 80;
  localparam int DEF_ROWS = 30;

  localparam logic [7:0] CH_BS    = 8'h08;
  localparam logic [7:0] CH_TAB   = 8'h09;
  localparam logic [7:0] CH_LF    = 8'h0A;
  localparam logic [7:0] CH_FF    = 8'h0C;
  localparam logic [7:0] CH_CR    = 8'h0D;
  localparam logic [7:0] CH_SPACE = 8'h20;
  localparam logic [7:0] CH_TILDE = 8'h7E;

  typedef enum logic [1:0] {
    CLR_ALL,
    IDLE,
    CLR_LINE
  } term_state_t;

  // Linear cell address; with cols=80 this reduces to (row<<6)+(row<<4)+col.
  function automatic logic [11:0] cell_addr(input logic [4:0] row, input logic [6:0] col,
                                            input int cols);
    return 12'(int'(row) * cols + int'(col));
  endfunction

endpackage

// File: rtl/term_writer.sv
// Byte-stream text terminal: tracks a cursor, interprets control codes and
// emits one registered framebuffer cell write per cycle, with full/line clears.
module term_writer
  import quasi_term_pkg::*;
#(
  parameter int         COLS       = DEF_COLS,
  parameter int         ROWS       = DEF_ROWS,
  parameter logic [7:0] CLEAR_ATTR = 8'h0F
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [7:0]  in_data,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [7:0]  attr,
  output logic [11:0] fb_a,
  output logic [15:0] fb_d,
  output logic        fb_we,
  output logic [4:0]  cur_row,
  output logic [6:0]  cur_col
);

  localparam logic [11:0] CELLS     = 12'(ROWS * COLS);
  localparam logic [11:0] LINE_LEN  = 12'(COLS);
  localparam logic [6:0]  LAST_COL  = 7'(COLS - 1);
  localparam logic [4:0]  LAST_ROW  = 5'(ROWS - 1);
  localparam logic [7:0]  TAB_LIMIT = 8'(COLS);
  localparam logic [15:0] BLANK     = {CLEAR_ATTR, CH_SPACE};

  term_state_t state_q;
  logic [11:0] clr_q;
  logic [4:0]  row_q;
  logic [6:0]  col_q;
  logic [11:0] fb_a_q;
  logic [15:0] fb_d_q;
  logic        fb_we_q;

  logic        accept_d;
  logic        is_print_d;
  logic [7:0]  tab_col_d;
  logic [4:0]  next_row_d;
  logic        line_end_d;
  logic [11:0] line_base_d;

  // NOTE: in_ready decodes state directly, so a byte offered while clearing is simply not taken.
  assign in_ready = (state_q == IDLE);

  always_comb begin
    accept_d    = in_valid && (state_q == IDLE);
    is_print_d  = (in_data >= CH_SPACE) && (in_data <= CH_TILDE);
    tab_col_d   = {1'b0, col_q | 7'd7} + 8'd1;
    next_row_d  = (row_q == LAST_ROW) ? 5'd0 : row_q + 5'd1;
    line_base_d = cell_addr(row_q, 7'd0, COLS);
    line_end_d  = accept_d && ((is_print_d && col_q == LAST_COL) ||
                               (in_data == CH_LF) ||
                               (in_data == CH_TAB && tab_col_d >= TAB_LIMIT));
  end

  // NOTE: every state register uses non-blocking assignment so all updates land on the same edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= CLR_ALL;
      clr_q   <= '0;
      row_q   <= '0;
      col_q   <= '0;
      fb_a_q  <= '0;
      fb_d_q  <= '0;
      fb_we_q <= 1'b0;
    end else begin
      fb_we_q <= 1'b0;
      unique case (state_q)
        CLR_ALL: begin
          if (clr_q == CELLS) begin
            state_q <= IDLE;
            clr_q   <= '0;
          end else begin
            fb_we_q <= 1'b1;
            fb_a_q  <= clr_q;
            fb_d_q  <= BLANK;
            clr_q   <= clr_q + 12'd1;
          end
        end
        CLR_LINE: begin
          if (clr_q == LINE_LEN) begin
            state_q <= IDLE;
            clr_q   <= '0;
          end else begin
            fb_we_q <= 1'b1;
            fb_a_q  <= line_base_d + clr_q;
            fb_d_q  <= BLANK;
            clr_q   <= clr_q + 12'd1;
          end
        end
        IDLE: begin
          if (accept_d) begin
            if (is_print_d) begin
              fb_we_q <= 1'b1;
              fb_a_q  <= cell_addr(row_q, col_q, COLS);
              fb_d_q  <= {attr, in_data};
              col_q   <= col_q + 7'd1;
            end else begin
              case (in_data)
                CH_CR:  col_q <= '0;
                CH_BS:  if (col_q != 7'd0) col_q <= col_q - 7'd1;
                CH_TAB: col_q <= tab_col_d[6:0];
                CH_FF: begin
                  state_q <= CLR_ALL;
                  clr_q   <= '0;
                  row_q   <= '0;
                  col_q   <= '0;
                end
                default: ;
              endcase
            end
            // Row advance overrides the column update above for wrap, LF and overflowing TAB.
            if (line_end_d) begin
              state_q <= CLR_LINE;
              clr_q   <= '0;
              row_q   <= next_row_d;
              col_q   <= '0;
            end
          end
        end
        default: state_q <= CLR_ALL;
      endcase
    end
  end

  assign fb_a    = fb_a_q;
  assign fb_d    = fb_d_q;
  assign fb_we   = fb_we_q;
  assign cur_row = row_q;
  assign cur_col = col_q;

endmodule
